// File: rtl/bit_masked_memory_pkg.sv
// Shared sizing, types and the per-bit write-merge rule for bit_masked_memory.
package bit_masked_memory_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Bits with mask=1 take the new value; all other bits keep the old value.
  function automatic word_t masked_merge(input word_t old_w, input word_t new_w, input word_t mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/bit_masked_memory.sv
// DEPTH x DATA_W register file with per-bit write mask and a one-cycle registered read.
// Synchronous active-low reset clears every word and the read register; no handshake, never stalls.
module bit_masked_memory
  import bit_masked_memory_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enb,
  input  logic  wr,
  input  addr_t addr,
  input  word_t data,
  input  word_t masked,
  output word_t r_data
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  word_t r_data_q, r_data_d;
  logic  addr_ok;

  // Only a non-power-of-two depth has unbacked addresses to screen out.
  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_partial_range
    assign addr_ok = (32'(addr) < DEPTH);
  end

  always_comb begin
    mem_d    = mem_q;
    r_data_d = r_data_q;
    if (enb) begin
      if (wr) begin
        if (addr_ok) begin
          mem_d[addr] = masked_merge(mem_q[addr], data, masked);
        end
      end else begin
        r_data_d = addr_ok ? mem_q[addr] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      r_data_q <= '0;
    end else begin
      mem_q    <= mem_d;
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;

endmodule

// File: tb/tb_bit_masked_memory.sv
// Scoreboarded random and directed test of bit_masked_memory against a per-bit array model.
module tb_bit_masked_memory;
  import bit_masked_memory_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  enb = 1'b0;
  logic  wr = 1'b0;
  addr_t addr = '0;
  word_t data = '0;
  word_t masked = '0;
  word_t r_data;

  bit_masked_memory dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enb    (enb),
    .wr     (wr),
    .addr   (addr),
    .data   (data),
    .masked (masked),
    .r_data (r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t exp;
    string nm;
  } sb_t;

  sb_t   sb_q[$];
  word_t model_mem [8];
  word_t model_r;
  int    total = 0;
  int    bad   = 0;

  function automatic word_t ref_merge(input word_t o, input word_t n, input word_t m);
    word_t r;
    for (int b = 0; b < DATA_W; b++) r[b] = m[b] ? n[b] : o[b];
    return r;
  endfunction

  // One clock of stimulus; the expected r_data after that edge goes to the scoreboard.
  task automatic cyc(input logic rst, input logic en, input logic w, input int a,
                     input word_t d, input word_t m, input string nm);
    rst_n  = rst;
    enb    = en;
    wr     = w;
    addr   = addr_t'(a);
    data   = d;
    masked = m;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) model_mem[i] = '0;
      model_r = '0;
    end else if (en) begin
      if (w) model_mem[a] = ref_merge(model_mem[a], d, m);
      else   model_r = model_mem[a];
    end
    sb_q.push_back('{model_r, nm});
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      total++;
      if (r_data !== e.exp) begin
        bad++;
        $display("FAIL %s: r_data=%h expected=%h at %0t", e.nm, r_data, e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    model_r = '0;

    // 1. reset clear
    cyc(0, 1, 1, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, "reset0");
    cyc(0, 1, 0, 5, 32'h0, 32'h0, "reset1");
    for (int a = 0; a < 8; a++) cyc(1, 1, 0, a, 32'h0, 32'h0, "reset_read");

    // 2. masked write, mask ignored on read
    cyc(1, 1, 1, 1, 32'hA5A5A5A5, 32'h00FF00FF, "mwrite");
    cyc(1, 1, 0, 1, 32'h0, 32'hA5A5A5A5, "mread");
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "mread_hold");

    // 3. merge preservation
    cyc(1, 1, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, "full_write");
    cyc(1, 1, 1, 2, 32'h00000000, 32'h0000FFFF, "low_clear");
    cyc(1, 1, 0, 2, 32'h0, 32'h0, "merge_read");
    cyc(1, 1, 1, 2, 32'h12345678, 32'h00000000, "zero_mask");
    cyc(1, 1, 0, 2, 32'h0, 32'h0, "zero_mask_read");

    // 4. enable gating
    cyc(1, 0, 1, 3, 32'hDEADBEEF, 32'hFFFFFFFF, "gated_write");
    cyc(1, 1, 0, 3, 32'h0, 32'h0, "gated_read");
    cyc(1, 1, 0, 2, 32'h0, 32'h0, "nonzero_read");
    for (int i = 0; i < 3; i++) cyc(1, 0, i[0], i, 32'hFFFFFFFF, 32'hFFFFFFFF, "idle_hold");

    // 5. address isolation
    for (int k = 0; k < 8; k++) cyc(1, 1, 1, k, 32'h11111111 * k, 32'hFFFFFFFF, "iso_write");
    for (int k = 0; k < 8; k++) cyc(1, 1, 0, k, 32'h0, 32'h0, "iso_read");

    // 6. reset mid-operation
    cyc(1, 1, 1, 4, 32'hCAFEF00D, 32'hFFFFFFFF, "pre_rst_write");
    cyc(1, 1, 0, 4, 32'h0, 32'h0, "pre_rst_read");
    cyc(0, 1, 1, 4, 32'h0, 32'hFFFF0000, "mid_rst");
    cyc(1, 1, 0, 4, 32'h0, 32'h0, "post_rst_read");
    cyc(1, 1, 0, 7, 32'h0, 32'h0, "post_rst_read7");

    // random traffic, rare resets
    for (int n = 0; n < 600; n++) begin
      logic rst, en, w;
      rst = ($urandom_range(0, 63) != 0);
      en  = ($urandom_range(0, 3) != 0);
      w   = $urandom_range(0, 1) == 1;
      cyc(rst, en, w, $urandom_range(0, 7), $urandom, $urandom, "random");
    end

    cyc(1, 0, 0, 0, 32'h0, 32'h0, "drain");
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_masked_memory.md
Name: bit_masked_memory

Overview:
Single-port synchronous register-file memory, 8 words x 32 bits, with per-bit write masking. Each write updates only the bits selected by a mask; all other stored bits are preserved. Reads are registered with one-cycle latency. It is a leaf storage block for small control/status tables that need partial-word updates.

Parameters:
DATA_W, 32, word width in bits; also the width of data, masked and r_data.
DEPTH, 8, number of words.
ADDR_W, $clog2(DEPTH) = 3, address width.

Ports:
clk     input   1        rising-edge clock
rst_n   input   1        synchronous reset, active-low
enb     input   1        access enable; no operation when low
wr      input   1        1 = write, 0 = read; sampled only when enb=1
addr    input   ADDR_W   word address
data    input   DATA_W   write data
masked  input   DATA_W   write bit-mask; 1 = bit is written, 0 = bit is kept
r_data  output  DATA_W   registered read data

Interface note: one clock (clk); reset is synchronous and active-low (rst_n).

Behaviour:
- All state changes occur on the rising edge of clk only.
- Reset: when rst_n=0 at a clock edge, all DEPTH words are cleared to 0 and r_data is cleared to 0. Reset has priority over enb and wr. Reset asserted mid-operation aborts any access in that cycle; no partial write occurs.
- Write (rst_n=1, enb=1, wr=1): mem[addr] <= (mem[addr] & ~masked) | (data & masked).
  - masked=0 leaves the word unchanged.
  - masked=all-ones performs a full-word write.
  - r_data holds its previous value during a write cycle.
- Read (rst_n=1, enb=1, wr=0): r_data <= mem[addr] at the edge, so data is visible one cycle after the request. The mask is ignored on reads and the full word is returned.
- Idle (enb=0): memory and r_data both hold; wr, addr, data and masked are don't-care.
- Back-to-back: a read in the cycle immediately after a write to the same address returns the newly merged value, since the write completed at the prior edge.
- Address range: every 3-bit address is valid and there is no wrap-around or out-of-range handling. If DEPTH is not a power of two, an address >= DEPTH ignores writes and reads return 0.
- There is no handshake; every enabled access completes in one cycle and the block never stalls.
- Outputs are never X after the first reset edge.

Decomposition:
- Shared package bit_masked_memory_pkg: DATA_W, DEPTH, ADDR_W localparams; typedef word_t (logic [DATA_W-1:0]); typedef addr_t (logic [ADDR_W-1:0]).
- Put the merge function, masked_merge(old, new, mask), in the package so verification can reuse it as the reference model.
- No sub-module is needed. The storage array and read register stay in the single module.

Test Plan:
1. Reset clear: hold rst_n=0 for 2 cycles, then release and read every address 0..7 -> r_data = 0x00000000 one cycle after each read.
2. Masked write after reset: write addr=1, data=0xA5A5A5A5, masked=0x00FF00FF. On the next cycle read addr=1 with masked=0xA5A5A5A5 (the mask must be ignored) -> r_data = 0x00A500A5 one cycle later.
3. Merge preservation:
   - Write addr=2, data=0xFFFFFFFF, masked=0xFFFFFFFF.
   - Then write addr=2, data=0x00000000, masked=0x0000FFFF.
   - Read addr=2 -> 0xFFFF0000.
   - Then write masked=0 with data=0x12345678 and read -> still 0xFFFF0000.
4. Enable gating:
   - With enb=0 and wr=1, drive addr=3, data=0xDEADBEEF, masked=0xFFFFFFFF; read addr=3 -> 0x00000000.
   - With enb=0, r_data must stay at its last value across cycles.
5. Address isolation: full writes of 0x11111111*k to addr k for k=0..7, then read all addresses -> each returns its own pattern, and r_data is unchanged during the write cycles.
6. Reset mid-operation: write addr=4 = 0xCAFEF00D; then assert rst_n=0 in the same cycle as a write to addr=4 of data=0x0, masked=0xFFFF0000; release and read addr=4 -> 0x00000000, and r_data = 0 immediately after the reset edge.
